// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: round-robin arbiter sharing one 8-bit LSB-first SPI master among N requesters.
// Ports: clk, reset (async, active-low); req/tx_data in; done/rx_data/busy out; SCLK/CS/MOSI out, MISO in.
module spi_bus_scheduler #(
  parameter int N    = 4,
  parameter int HALF = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] tx_data,
  output logic [N-1:0]   done,
  output logic [7:0]     rx_data,
  output logic           busy,
  output logic           SCLK,
  output logic [N-1:0]   CS,
  output logic           MOSI,
  input  logic           MISO
);

  localparam int LW = $clog2(N);
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PEND = PW'(HALF - 1);
  localparam logic [LW-1:0] LMAX = LW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [LW-1:0] last, last_n;
  logic [LW-1:0] win, win_n;
  logic [7:0]    tx, tx_n;
  logic [7:0]    rx_sh, rx_n;
  logic [7:0]    rx_data_n;
  logic          sclk_n, mosi_n;
  logic [N-1:0]  cs_n, done_n;
  logic          hold_end;

  logic [LW-1:0] pick;
  logic          hit;

  // First requester at or after last+1, wrapping past N-1.
  always_comb begin
    int idx;
    pick = '0;
    hit  = 1'b0;
    idx  = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && req[idx]) begin
        pick = LW'(idx);
        hit  = 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign hold_end = (phase == PEND);

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bit_n     = bit_cnt;
    last_n    = last;
    win_n     = win;
    tx_n      = tx;
    rx_n      = rx_sh;
    rx_data_n = rx_data;
    sclk_n    = SCLK;
    mosi_n    = MOSI;
    cs_n      = CS;
    done_n    = '0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          win_n   = pick;
          last_n  = pick;
          tx_n    = tx_data[8*pick +: 8];
          cs_n    = ~(N'(1) << pick);
          phase_n = '0;
          bit_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (hold_end) begin
          phase_n = '0;
          sclk_n  = 1'b1;
          mosi_n  = tx[0];
          state_n = HIGH;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      HIGH: begin
        if (hold_end) begin
          phase_n        = '0;
          sclk_n         = 1'b0;
          rx_n[bit_cnt]  = MISO;
          state_n        = LOW;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      LOW: begin
        if (hold_end) begin
          phase_n = '0;
          if (bit_cnt != 3'd7) begin
            bit_n   = bit_cnt + 3'd1;
            sclk_n  = 1'b1;
            mosi_n  = tx[bit_cnt + 3'd1];
            state_n = HIGH;
          end else begin
            cs_n        = '1;
            mosi_n      = 1'b0;
            rx_data_n   = rx_sh;
            done_n[win] = 1'b1;
            state_n     = GAP;
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      GAP: begin
        if (hold_end) begin
          phase_n = '0;
          state_n = IDLE;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      last    <= LMAX;
      win     <= '0;
      tx      <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      CS      <= '1;
      done    <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bit_cnt <= bit_n;
      last    <= last_n;
      win     <= win_n;
      tx      <= tx_n;
      rx_sh   <= rx_n;
      rx_data <= rx_data_n;
      SCLK    <= sclk_n;
      MOSI    <= mosi_n;
      CS      <= cs_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// tb_spi_bus_scheduler: directed bench for two scheduler instances
// (a: N=4 HALF=2, b: N=4 HALF=1) with per-chip-select slave models.
module tb_spi_bus_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst_a, rst_b;
  logic [3:0]  req_a, req_b, done_a, done_b, cs_a, cs_b;
  logic [31:0] tx_a, tx_b;
  logic [7:0]  rx_a, rx_b;
  logic        busy_a, busy_b, sclk_a, sclk_b, mosi_a, mosi_b;
  logic        miso_a = 1'b0;
  logic        miso_b = 1'b0;

  spi_bus_scheduler #(.N(4), .HALF(2)) u_a (
    .clk(clk), .reset(rst_a), .req(req_a), .tx_data(tx_a),
    .done(done_a), .rx_data(rx_a), .busy(busy_a),
    .SCLK(sclk_a), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a)
  );

  spi_bus_scheduler #(.N(4), .HALF(1)) u_b (
    .clk(clk), .reset(rst_b), .req(req_b), .tx_data(tx_b),
    .done(done_b), .rx_data(rx_b), .busy(busy_b),
    .SCLK(sclk_b), .CS(cs_b), .MOSI(mosi_b), .MISO(miso_b)
  );

  // Slave replies per chip-select, and bus observations.
  logic [7:0] sb_a [4];
  logic [7:0] sb_b [4];
  logic [3:0] csp_a = 4'hF, csp_b = 4'hF;
  logic       sp_a = 1'b0, sp_b = 1'b0;
  logic       multi_a = 1'b0, multi_b = 1'b0;
  logic [7:0] mc_a = 8'h00, mc_b = 8'h00;
  int sel_a = 0, sel_b = 0, sidx_a = 0, sidx_b = 0;
  int lc_a = 0, lc_b = 0, gt_a = 0, gt_b = 0, fr_a = 0, dc_a = 0, dc_b = 0;
  int tq_a[$], tq_b[$], lq_a[$], lq_b[$];

  always @(negedge clk) begin
    if ($countones(~cs_a) > 1) multi_a = 1'b1;
    if (|done_a) dc_a++;
    if (cs_a != 4'hF && csp_a == 4'hF) begin
      lc_a = 0; gt_a = cyc; fr_a = -1; sidx_a = 0; mc_a = 8'h00;
      for (int i = 0; i < 4; i++) if (!cs_a[i]) sel_a = i;
      tq_a.push_back(cyc);
    end
    if (cs_a != 4'hF) lc_a++;
    if (cs_a == 4'hF && csp_a != 4'hF) lq_a.push_back(lc_a);
    if (sclk_a && !sp_a) begin
      if (fr_a < 0) fr_a = cyc - gt_a;
      if (sidx_a < 8) miso_a = sb_a[sel_a][sidx_a];
      sidx_a++;
    end
    if (!sclk_a && sp_a) mc_a = {mosi_a, mc_a[7:1]};
    csp_a = cs_a;
    sp_a  = sclk_a;
  end

  always @(negedge clk) begin
    if ($countones(~cs_b) > 1) multi_b = 1'b1;
    if (|done_b) dc_b++;
    if (cs_b != 4'hF && csp_b == 4'hF) begin
      lc_b = 0; gt_b = cyc; sidx_b = 0; mc_b = 8'h00;
      for (int i = 0; i < 4; i++) if (!cs_b[i]) sel_b = i;
      tq_b.push_back(cyc);
    end
    if (cs_b != 4'hF) lc_b++;
    if (cs_b == 4'hF && csp_b != 4'hF) lq_b.push_back(lc_b);
    if (sclk_b && !sp_b) begin
      if (sidx_b < 8) miso_b = sb_b[sel_b][sidx_b];
      sidx_b++;
    end
    if (!sclk_b && sp_b) mc_b = {mosi_b, mc_b[7:1]};
    csp_b = cs_b;
    sp_b  = sclk_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit b, output logic [3:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while ((b ? done_b : done_a) == 4'd0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    d = b ? done_b : done_a;
    chk("done_seen", 32'(|d), 32'd1);
  endtask

  task automatic wait_idle(input bit b);
    int n;
    n = 0;
    @(negedge clk);
    while ((b ? busy_b : busy_a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_seen", 32'(b ? !busy_b : !busy_a), 32'd1);
  endtask

  task automatic wait_grant(input bit b);
    int n;
    n = 0;
    @(negedge clk);
    while ((b ? cs_b : cs_a) == 4'hF && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("grant_seen", 32'((b ? cs_b : cs_a) != 4'hF), 32'd1);
  endtask

  logic [3:0] d;
  int dcs;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = '0; req_b = '0;
    tx_a = '0; tx_b = '0;
    sb_a = '{8'h3C, 8'h96, 8'h5A, 8'hC3};
    sb_b = '{8'h5A, 8'h00, 8'hFF, 8'h5A};
    repeat (3) @(negedge clk);

    chk("rst_cs", 32'(cs_a), 32'hF);
    chk("rst_sclk", 32'(sclk_a), 32'd0);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_rx", 32'(rx_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_cs_b", 32'(cs_b), 32'hF);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // single transfer on requester 0
    tx_a  = 32'h0000_00A5;
    req_a = 4'b0001;
    wait_done(1'b0, d);
    chk("t1_done", 32'(d), 32'h1);
    chk("t1_rx", 32'(rx_a), 32'h3C);
    chk("t1_mosi", 32'(mc_a), 32'hA5);
    chk("t1_latency", 32'(cyc - gt_a), 32'd34);
    chk("t1_first_rise", 32'(fr_a), 32'd2);
    req_a = '0;
    @(negedge clk);
    chk("t1_pulse_len", 32'(done_a), 32'd0);
    wait_idle(1'b0);
    chk("t1_cs_len", 32'(lq_a[$]), 32'd34);
    chk("t1_done_cnt", 32'(dc_a), 32'd1);

    // round-robin wrap
    tx_a  = 32'h4433_2211;
    req_a = 4'b1000;
    wait_done(1'b0, d);
    chk("t2_first", 32'(d), 32'h8);
    chk("t2_rx3", 32'(rx_a), 32'hC3);
    req_a = '0;
    wait_idle(1'b0);
    req_a = 4'b1010;
    wait_done(1'b0, d);
    chk("t2_second", 32'(d), 32'h2);
    req_a = req_a & ~d;
    wait_done(1'b0, d);
    chk("t2_third", 32'(d), 32'h8);
    req_a = '0;
    wait_idle(1'b0);

    // full contention
    tq_a.delete();
    multi_a = 1'b0;
    req_a = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_done(1'b0, d);
      chk("t3_order", 32'(d), 32'(1) << k);
      chk("t3_rx", 32'(rx_a), 32'(sb_a[k]));
      req_a = req_a & ~d;
    end
    wait_idle(1'b0);
    chk("t3_gap01", 32'(tq_a[1] - tq_a[0]), 32'd37);
    chk("t3_gap23", 32'(tq_a[3] - tq_a[2]), 32'd37);
    chk("t3_one_cs", 32'(multi_a), 32'd0);

    // drop req and change tx_data mid-transfer
    tx_a  = 32'h0081_0000;
    req_a = 4'b0100;
    wait_grant(1'b0);
    req_a = '0;
    tx_a  = 32'h007E_0000;
    wait_done(1'b0, d);
    chk("t4_done", 32'(d), 32'h4);
    chk("t4_mosi", 32'(mc_a), 32'h81);
    chk("t4_rx", 32'(rx_a), 32'h5A);
    wait_idle(1'b0);
    repeat (4) @(negedge clk);
    chk("t4_no_regrant", 32'(busy_a), 32'd0);

    // reset around bit 4
    tx_a  = 32'h0000_00A5;
    req_a = 4'b0001;
    wait_grant(1'b0);
    repeat (19) @(negedge clk);
    dcs   = dc_a;
    rst_a = 1'b0;
    #1;
    chk("t5_cs", 32'(cs_a), 32'hF);
    chk("t5_sclk", 32'(sclk_a), 32'd0);
    chk("t5_mosi", 32'(mosi_a), 32'd0);
    chk("t5_busy", 32'(busy_a), 32'd0);
    chk("t5_done", 32'(done_a), 32'd0);
    chk("t5_rx", 32'(rx_a), 32'd0);
    req_a = 4'b0011;
    repeat (3) @(negedge clk);
    chk("t5_no_done", 32'(dc_a), 32'(dcs));
    rst_a = 1'b1;
    wait_done(1'b0, d);
    chk("t5_ptr_reset", 32'(d), 32'h1);
    chk("t5_rx_after", 32'(rx_a), 32'h3C);
    req_a = '0;
    wait_idle(1'b0);

    // HALF=1 back-to-back on requesters 1 and 2
    tx_b  = 32'h0000_FF00;
    req_b = 4'b0110;
    wait_done(1'b1, d);
    chk("t6_first", 32'(d), 32'h2);
    chk("t6_rx1", 32'(rx_b), 32'h00);
    chk("t6_mosi1", 32'(mc_b), 32'hFF);
    req_b = req_b & ~d;
    wait_done(1'b1, d);
    chk("t6_second", 32'(d), 32'h4);
    chk("t6_rx2", 32'(rx_b), 32'hFF);
    chk("t6_mosi2", 32'(mc_b), 32'h00);
    req_b = '0;
    wait_idle(1'b1);
    chk("t6_len1", 32'(lq_b[0]), 32'd17);
    chk("t6_len2", 32'(lq_b[1]), 32'd17);
    chk("t6_g2g", 32'(tq_b[1] - tq_b[0]), 32'd19);
    chk("t6_one_cs", 32'(multi_b), 32'd0);
    chk("t6_done_cnt", 32'(dc_b), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_scheduler.md
# spi_bus_scheduler

Shares one SPI master port between `N` requesters, each owning one slave chip-select, and sequences every 8-bit full-duplex transfer. It sits above the SPI slaves on the bus. It generates SCLK from the system clock, drives CS/MOSI, captures MISO, and returns the received byte to the requester that won arbitration. Bus protocol matches the team's slaves:
- CS active-low.
- SCLK idles low.
- LSB first.
- Slave drives MISO on SCLK rise and samples MOSI on SCLK fall.

## Interface
- `N`, 4: number of requesters and chip-selects (2..8).
- `HALF`, 2: SCLK half-period in `clk` cycles (≥1).
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req` input N: `req[i]` high requests one transfer for requester i.
- `tx_data` input 8N: byte for requester i at `[8i+7:8i]`, latched at grant.
- `done` output N: `done[i]` one-cycle pulse when requester i's transfer completes.
- `rx_data` output 8: byte received in the last completed transfer; holds until the next completion.
- `busy` output 1: high whenever the state is not IDLE.
- `SCLK` output 1: SPI clock.
- `CS` output N: active-low selects; `CS[i]` serves requester i; at most one low.
- `MOSI` output 1: master data out.
- `MISO` input 1: slave data in.

## Operation
- Reset values: `SCLK`=0, `CS`=all 1, `MOSI`=0, `done`=0, `rx_data`=0, `busy`=0, state IDLE, priority pointer `last`=N-1, bit counter 0, phase counter 0.
- States are IDLE, SETUP, HIGH, LOW, GAP.
- IDLE:
  - If any `req` is high, grant winner w: the first set bit searching from `(last+1) mod N` upward with wrap.
  - Latch `tx_data[w]`, set `last`=w, drive `CS[w]`=0 and go to SETUP.
  - No request: stay in IDLE.
- SETUP: `SCLK`=0 for HALF cycles. On exit: `SCLK`←1, `MOSI`←tx[0], go to HIGH.
- HIGH: hold HALF cycles. On exit: `SCLK`←0, capture rx[bit]←`MISO` on that same edge, go to LOW.
- LOW: hold HALF cycles. On exit:
  - If bit<7: bit←bit+1, `SCLK`←1, `MOSI`←tx[bit+1], go to HIGH.
  - If bit=7: `CS`←all 1, `MOSI`←0, `rx_data`←assembled byte, `done[w]`←1 for one cycle, go to GAP.
- GAP: CS high for HALF cycles, then IDLE. Arbitration occurs only in IDLE, so `busy` drops for at least one cycle between transfers.
- Round-robin guarantees a continuously requesting requester waits at most N-1 transfers.
- Dropping `req[w]` after grant does not abort the transfer; `done[w]` still pulses.
- A requester must drop `req` the cycle after `done`, or it is treated as a new request.
- Changes to `tx_data` after grant are ignored.
- A new `req` arriving during a transfer is only considered at the next IDLE.
- Asserting `reset` mid-transfer returns all outputs to reset values immediately. No `done` pulses and `rx_data` is not updated.

## Timing
- Grant edge t0: `CS[w]` falls and `busy` rises at t0.
- SCLK rising edges at t0+HALF·(1+2k) for k=0..7.
- SCLK falling edges and MISO captures at t0+HALF·(2+2k).
- `CS[w]` rises, `rx_data` updates and `done[w]` asserts at t0+17·HALF.
- `done[w]` deasserts at t0+17·HALF+1.
- IDLE re-entered (`busy`=0) at t0+18·HALF; the earliest next grant is t0+18·HALF+1.
- MOSI is stable from each SCLK rise through the following fall. MISO is sampled HALF cycles after the slave drives it.

## Test plan
- Single transfer, N=4, HALF=2. `req[0]`, tx 0xA5; slave model returns 0x3C.
  - MOSI at successive SCLK rises reads 1,0,1,0,0,1,0,1.
  - `CS[0]` low for exactly 34 cycles; `rx_data`=0x3C; one `done[0]` pulse at t0+34.
- Full contention: all four `req` held, each dropped on its `done`. Grants in order 0,1,2,3; 37 cycles grant-to-grant; never two CS low.
- Round-robin wrap: `req[3]` served first. Then `req[1]` and `req[3]` both high. Next grant is 1, then 3.
- Requester drops `req[2]` and changes `tx_data` mid-transfer. Original byte 0x81 is still shifted out; `done[2]` pulses.
- Reset asserted at bit 4. `CS`=all 1, `SCLK`=0, `MOSI`=0, `busy`=0 immediately; no `done`.
  - After release, `req[0]` is granted first (pointer reset).
- HALF=1, tx 0xFF / MISO 0x00 back-to-back with tx 0x00 / MISO 0xFF on requesters 1 and 2.
  - `rx_data` reads 0x00, then 0xFF.
  - CS low for 17 cycles each.
